// File: rtl/picomips_core_p.sv
// picomips_core_p: parametrised accumulator processor, FETCH/LOAD/EXEC over an external synchronous ROM.
// Build option PICOMIPS_SAT_EN: ADD/ADDI/MULI results saturate instead of wrapping.
module picomips_core_p #(
  parameter int DATA_W    = 8,
  parameter int ARG_W     = 5,
  parameter int NREGS     = 2,
  parameter int PC_W      = 5,
  parameter int FRAC_W    = 2,
  parameter int IMM_SHIFT = 1
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              sw_flag,
  output logic [PC_W-1:0]   instr_addr,
  input  logic [ARG_W+2:0]  instr_data,
  output logic [DATA_W-1:0] led,
  output logic              waiting
);
  localparam int INSTR_W = ARG_W + 3;
  localparam int W       = 2*DATA_W + ARG_W + IMM_SHIFT + 2;

  typedef enum logic [1:0] {S_FETCH, S_LOAD, S_EXEC} state_t;
  typedef enum logic [2:0] {OP_JMP, OP_LSW, OP_RTA, OP_ATR, OP_ADD, OP_ADDI, OP_MULI, OP_HEI} op_t;

  state_t              state_reg;
  logic [PC_W-1:0]     pc_reg;
  logic [DATA_W-1:0]   acc_reg;
  logic [DATA_W-1:0]   rd_reg;
  logic [DATA_W-1:0]   rd_next;
  logic [DATA_W-1:0]   alu_out;
  logic [INSTR_W-1:0]  ir_reg;
  logic [DATA_W-1:0]   regs_reg [NREGS];
  op_t                 op;
  logic [ARG_W-1:0]    ir_arg;
  logic [ARG_W-1:0]    ld_arg;
  logic signed [W-1:0] acc_w;
  logic signed [W-1:0] rd_w;
  logic signed [W-1:0] arg_w;
  logic signed [W-1:0] res_w;
  logic                stall;
  logic                reg_wr;

  assign op         = op_t'(ir_reg[INSTR_W-1 -: 3]);
  assign ir_arg     = ir_reg[ARG_W-1:0];
  assign ld_arg     = instr_data[ARG_W-1:0];
  assign stall      = (op == OP_HEI) && (sw_flag == ir_arg[0]);
  assign reg_wr     = (state_reg == S_EXEC) && (op == OP_ATR);
  assign instr_addr = pc_reg;
  assign led        = acc_reg;

  // Register indices beyond NREGS read as zero and are never written.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NREGS; i++)
      if (32'(ld_arg) == i) rd_next = regs_reg[i];
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < NREGS; i++) regs_reg[i] <= '0;
    end else if (reg_wr) begin
      for (int i = 0; i < NREGS; i++)
        if (32'(ir_arg) == i) regs_reg[i] <= acc_reg;
    end
  end

  // Arithmetic is carried out wide enough that no intermediate overflows.
  always_comb begin
    acc_w = W'($signed(acc_reg));
    rd_w  = W'($signed(rd_reg));
    arg_w = W'($signed(ir_arg));
    case (op)
      OP_ADD:  res_w = acc_w + rd_w;
      OP_ADDI: res_w = acc_w + (arg_w <<< IMM_SHIFT);
      OP_MULI: res_w = (acc_w * arg_w) >>> FRAC_W;
      default: res_w = acc_w;
    endcase
  end

`ifdef PICOMIPS_SAT_EN
  localparam logic signed [W-1:0] SAT_MAX = W'((2**(DATA_W-1)) - 1);
  localparam logic signed [W-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    if (res_w > SAT_MAX)      alu_out = SAT_MAX[DATA_W-1:0];
    else if (res_w < SAT_MIN) alu_out = SAT_MIN[DATA_W-1:0];
    else                      alu_out = res_w[DATA_W-1:0];
  end
`else
  logic unused_hi;
  assign unused_hi = ^res_w[W-1:DATA_W];
  assign alu_out   = res_w[DATA_W-1:0];
`endif

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_reg <= S_FETCH;
      pc_reg    <= '0;
      acc_reg   <= '0;
      ir_reg    <= '0;
      rd_reg    <= '0;
      waiting   <= 1'b0;
    end else begin
      case (state_reg)
        S_FETCH: state_reg <= S_LOAD;
        S_LOAD: begin
          ir_reg    <= instr_data;
          rd_reg    <= rd_next;
          state_reg <= S_EXEC;
        end
        S_EXEC: begin
          if (stall) begin
            waiting <= 1'b1;
          end else begin
            waiting   <= 1'b0;
            state_reg <= S_FETCH;
            pc_reg    <= (op == OP_JMP) ? PC_W'(ir_arg) : pc_reg + PC_W'(1);
            case (op)
              OP_LSW:                   acc_reg <= sw_data;
              OP_RTA:                   acc_reg <= rd_reg;
              OP_ADD, OP_ADDI, OP_MULI: acc_reg <= alu_out;
              default: ;
            endcase
          end
        end
        default: state_reg <= S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_picomips_core_p.sv
// tb_picomips_core_p: random and directed programs run against an instruction-level reference model.
// Expected (pc, acc) per retired instruction is queued; a monitor pops and compares on each retirement.
module tb_picomips_core_p;
  localparam int NREGS  = 2;
  localparam int NINSTR = 40;
  localparam int NRUNS  = 8;
  localparam int OP_JMP = 0, OP_LSW = 1, OP_RTA = 2, OP_ATR = 3;
  localparam int OP_ADD = 4, OP_ADDI = 5, OP_MULI = 6, OP_HEI = 7;

  logic       Clock = 1'b0;
  logic       nReset = 1'b0;
  logic [7:0] sw_data = 8'd0;
  logic       sw_flag = 1'b0;
  logic [4:0] instr_addr;
  logic [7:0] instr_data;
  logic [7:0] led;
  logic       waiting;
  logic [7:0] rom [32];

  typedef struct { int pc; int acc; bit hei; } exp_t;
  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;

  always #5 Clock = ~Clock;
  always @(posedge Clock) instr_data <= rom[instr_addr];

  picomips_core_p dut (
    .Clock(Clock), .nReset(nReset), .sw_data(sw_data), .sw_flag(sw_flag),
    .instr_addr(instr_addr), .instr_data(instr_data), .led(led), .waiting(waiting)
  );

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] mk(input int op, input int arg);
    logic [2:0] o;
    logic [4:0] a;
    o = op[2:0];
    a = arg[4:0];
    return {o, a};
  endfunction

  function automatic int fix(input int v);
    int w;
`ifdef PICOMIPS_SAT_EN
    w = (v > 127) ? 127 : ((v < -128) ? -128 : v);
`else
    w = ((v % 256) + 256) % 256;
    if (w > 127) w = w - 256;
`endif
    return w;
  endfunction

  // Instruction-level model: walks the ROM from pc 0 and queues the state after each instruction.
  task automatic build_expect(input int swv);
    int pc, acc, op, arg, sarg, rv, nxt, p;
    int r [NREGS];
    logic [7:0] w;
    pc = 0;
    acc = 0;
    for (int i = 0; i < NREGS; i++) r[i] = 0;
    for (int k = 0; k < NINSTR; k++) begin
      w    = rom[pc];
      op   = int'(w[7:5]);
      arg  = int'(w[4:0]);
      sarg = (arg >= 16) ? arg - 32 : arg;
      rv   = (arg < NREGS) ? r[arg] : 0;
      nxt  = (pc + 1) % 32;
      case (op)
        OP_JMP:  nxt = arg % 32;
        OP_LSW:  acc = swv;
        OP_RTA:  acc = rv;
        OP_ATR:  if (arg < NREGS) r[arg] = acc;
        OP_ADD:  acc = fix(acc + rv);
        OP_ADDI: acc = fix(acc + sarg * 2);
        OP_MULI: begin
          p   = acc * sarg;
          acc = fix((p >= 0) ? p / 4 : -((-p + 3) / 4));
        end
        default: ;
      endcase
      pc = nxt;
      exp_q.push_back('{pc: pc, acc: acc, hei: (op == OP_HEI)});
    end
  endtask

  // Releases an HEI stall after a random number of waiting cycles.
  initial begin
    int cnt;
    int lim;
    cnt = 0;
    lim = 10;
    forever begin
      @(negedge Clock);
      if (nReset && waiting) cnt++;
      else cnt = 0;
      if (cnt >= lim) begin
        sw_flag = ~sw_flag;
        cnt = 0;
        lim = $urandom_range(3, 12);
      end
    end
  end

  // Monitor: an instruction retires on its third edge, or on the first edge after waiting drops.
  initial begin
    int phase, stall, last_pc, last_acc;
    exp_t e;
    phase = 0; stall = 0; last_pc = 0; last_acc = 0;
    forever begin
      @(posedge Clock);
      #1;
      if (!nReset) begin
        phase = 0; stall = 0; last_pc = 0; last_acc = 0;
        continue;
      end
      if (exp_q.size() == 0) continue;
      if (phase < 2) begin
        phase++;
        chk("wait_idle", int'(waiting), 0);
        chk("pc_hold", int'(instr_addr), last_pc);
        chk("led_hold", int'($signed(led)), last_acc);
      end else if (waiting) begin
        stall++;
        if (!exp_q[0].hei) chk("spurious_wait", 1, 0);
        chk("stall_pc", int'(instr_addr), last_pc);
        if (stall > 60) begin
          chk("stall_timeout", stall, 60);
          exp_q.delete();
        end
      end else begin
        e = exp_q.pop_front();
        $display("retire pc=%0d led=%0d (expect pc=%0d acc=%0d, stall=%0d)",
                 instr_addr, $signed(led), e.pc, e.acc, stall);
        chk("retire_pc", int'(instr_addr), e.pc);
        chk("retire_led", int'($signed(led)), e.acc);
        last_pc = e.pc;
        last_acc = e.acc;
        phase = 0;
        stall = 0;
      end
    end
  end

  // Stimulus: one program per run, each entered through a reset (mid-instruction after run 0).
  initial begin
    int swv;
    int cyc;
    for (int i = 0; i < 32; i++) rom[i] = mk(OP_ADDI, 1);
    for (int run = 0; run < NRUNS; run++) begin
      if (run == 0) begin
        @(posedge Clock);
      end else begin
        @(posedge Clock);
        #($urandom_range(2, 8));
        nReset = 1'b0;
      end
      #1;
      chk("reset_addr", int'(instr_addr), 0);
      chk("reset_led", int'(led), 0);
      chk("reset_waiting", int'(waiting), 0);
      if (run == 0) begin
        rom[0]  = mk(OP_LSW, 0);   rom[1]  = mk(OP_MULI, 3);
        rom[2]  = mk(OP_LSW, 0);   rom[3]  = mk(OP_MULI, 30);
        rom[4]  = mk(OP_LSW, 0);   rom[5]  = mk(OP_ATR, 0);
        rom[6]  = mk(OP_ADD, 0);   rom[7]  = mk(OP_ADDI, 10);
        rom[8]  = mk(OP_ADDI, 10); rom[9]  = mk(OP_ADDI, 10);
        rom[10] = mk(OP_ATR, 1);   rom[11] = mk(OP_LSW, 0);
        rom[12] = mk(OP_RTA, 1);   rom[13] = mk(OP_HEI, 0);
        rom[14] = mk(OP_ATR, 5);   rom[15] = mk(OP_RTA, 7);
        rom[16] = mk(OP_ADD, 3);   rom[17] = mk(OP_JMP, 7);
        sw_data = 8'd40;
        sw_flag = 1'b0;
      end else if (run == 1) begin
        for (int i = 0; i < 32; i++) rom[i] = mk(OP_ADDI, 1);
        rom[0]  = mk(OP_JMP, 28);
        rom[30] = mk(OP_HEI, 1);
        sw_data = 8'($urandom);
        sw_flag = 1'b1;
      end else begin
        for (int i = 0; i < 32; i++) rom[i] = 8'($urandom);
        sw_data = 8'($urandom);
        sw_flag = 1'($urandom);
      end
      swv = int'($signed(sw_data));
      build_expect(swv);
      $display("run %0d: sw_data=%0d, %0d instructions queued", run, swv, exp_q.size());
      @(posedge Clock);
      @(negedge Clock);
      nReset = 1'b1;
      cyc = 0;
      while (cyc < 4000 && exp_q.size() != 0) begin
        @(negedge Clock);
        cyc++;
      end
      if (exp_q.size() != 0) begin
        chk("run_timeout", exp_q.size(), 0);
        exp_q.delete();
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
